load_store_unit: RTL

//  Parametrised multi-cycle load/store unit for the MEM stage, replacing the single-cycle data-memory path.

---
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: req/ack data bus, lane steering, write masks, load extension.
// Latency: done 2 cycles after acceptance (1 beat), 3 (split), 1 (fault); bus wait states add cycles.
// Backpressure: stall holds the pipeline until RESP; bus beats wait on bus_ack. LSU_MISALIGNED_EN splits spills.
module load_store_unit #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [XLEN-1:0]   rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [AW-1:0]     bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wmask,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_rdata
);
    localparam int NB  = XLEN / 8;
    localparam int NB2 = 2 * NB;
    localparam int OW  = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_BEAT1, S_BEAT2, S_RESP} state_t;
    state_t r_state, w_next;

    logic              r_bus_req, r_bus_we, r_fault, r_uns, r_split;
    logic [AW-1:0]     r_bus_addr;
    logic [XLEN-1:0]   r_bus_wdata, r_wdata2, r_beat1, r_rdata;
    logic [NB-1:0]     r_bus_wmask, r_wmask2;
    logic [1:0]        r_size;
    logic [OW-1:0]     r_off;

    logic [OW-1:0]     w_off;
    logic [3:0]        w_bytes;
    logic              w_spill, w_illegal, w_misal, w_fault, w_split;
    logic [NB2-1:0]    w_mask2x;
    logic [2*XLEN-1:0] w_wdata2x, w_rd2x;
    logic [XLEN-1:0]   w_raw, w_lmask, w_ext;
    logic              w_sign;

    assign w_off = req_addr[OW-1:0];

    always_comb begin
        case (req_size)
            2'd0:    w_bytes = 4'd1;
            2'd1:    w_bytes = 4'd2;
            2'd2:    w_bytes = 4'd4;
            default: w_bytes = 4'd8;
        endcase
    end

    assign w_spill   = (5'(w_off) + 5'(w_bytes)) > 5'(NB);
    assign w_illegal = (XLEN == 32) && (req_size == 2'd3);
    assign w_misal   = (5'(w_off) & (5'(w_bytes) - 5'd1)) != 5'd0;
    assign w_mask2x  = NB2'((16'd1 << w_bytes) - 16'd1) << w_off;
    assign w_wdata2x = {{XLEN{1'b0}}, req_wdata} << {w_off, 3'b000};

`ifdef LSU_MISALIGNED_EN
    assign w_fault = w_illegal;
    assign w_split = w_spill;
`else
    assign w_fault = w_illegal | w_misal;
    assign w_split = 1'b0;
`endif

    // Second beat supplies the upper half of the two-word window; single beats leave it zero.
    assign w_rd2x = (r_state == S_BEAT2) ? {bus_rdata, r_beat1} : {{XLEN{1'b0}}, bus_rdata};
    assign w_raw  = XLEN'(w_rd2x >> {r_off, 3'b000});

    always_comb begin
        case (r_size)
            2'd0:    begin w_lmask = XLEN'(8'hFF);         w_sign = w_raw[7];  end
            2'd1:    begin w_lmask = XLEN'(16'hFFFF);      w_sign = w_raw[15]; end
            2'd2:    begin w_lmask = XLEN'(32'hFFFF_FFFF); w_sign = w_raw[31]; end
            default: begin w_lmask = '1;                   w_sign = 1'b0;      end
        endcase
        w_ext = (w_raw & w_lmask) | ((w_sign && !r_uns) ? ~w_lmask : '0);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_fault ? S_RESP : S_BEAT1;
            S_BEAT1: if (bus_ack)   w_next = r_split ? S_BEAT2 : S_RESP;
            S_BEAT2: if (bus_ack)   w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wmask <= '0;
            r_wdata2    <= '0;
            r_wmask2    <= '0;
            r_beat1     <= '0;
            r_rdata     <= '0;
            r_fault     <= 1'b0;
            r_uns       <= 1'b0;
            r_split     <= 1'b0;
            r_size      <= '0;
            r_off       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_size  <= req_size;
                    r_uns   <= req_unsigned;
                    r_off   <= w_off;
                    r_fault <= w_fault;
                    r_split <= w_split;
                    if (w_fault) begin
                        r_rdata <= '0;
                    end else begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= req_we;
                        r_bus_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
                        r_bus_wdata <= req_we ? w_wdata2x[XLEN-1:0] : '0;
                        r_bus_wmask <= req_we ? w_mask2x[NB-1:0] : '0;
                        r_wdata2    <= req_we ? w_wdata2x[2*XLEN-1:XLEN] : '0;
                        r_wmask2    <= req_we ? w_mask2x[NB2-1:NB] : '0;
                    end
                end
                S_BEAT1: if (bus_ack) begin
                    r_beat1 <= bus_rdata;
                    if (r_split) begin
                        r_bus_addr  <= r_bus_addr + AW'(NB);
                        r_bus_wdata <= r_wdata2;
                        r_bus_wmask <= r_wmask2;
                    end else begin
                        r_bus_req <= 1'b0;
                        r_rdata   <= r_bus_we ? '0 : w_ext;
                    end
                end
                S_BEAT2: if (bus_ack) begin
                    r_bus_req <= 1'b0;
                    r_rdata   <= r_bus_we ? '0 : w_ext;
                end
                default: r_fault <= 1'b0;
            endcase
        end
    end

    assign stall     = req_valid && (r_state != S_RESP) && !reset;
    assign done      = (r_state == S_RESP);
    assign fault     = r_fault;
    assign rdata     = r_rdata;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_wmask = r_bus_wmask;
endmodule
